// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded control, operands and instruction fields for EX,
// with flush > freeze > bubble > load priority and a saturating issued-instruction counter.
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              freeze,
    input  logic              bubble,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val_rn_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic [3:0]        dest_in,
    input  logic [3:0]        src1_in,
    input  logic [3:0]        src2_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       signed_imm_24_in,
    input  logic [3:0]        status_in,
    input  logic [3:0]        execute_command_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              wb_enable_in,
    input  logic              immediate_in,
    input  logic              branch_taken_in,
    input  logic              status_write_enable_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] val_rn_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic [3:0]        dest_out,
    output logic [3:0]        src1_out,
    output logic [3:0]        src2_out,
    output logic [11:0]       shift_operand_out,
    output logic [23:0]       signed_imm_24_out,
    output logic [3:0]        status_out,
    output logic [3:0]        execute_command_out,
    output logic              mem_read_out,
    output logic              mem_write_out,
    output logic              wb_enable_out,
    output logic              immediate_out,
    output logic              branch_taken_out,
    output logic              status_write_enable_out,
    output logic [CNT_W-1:0]  issued_count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    // Side-effecting control only passes for a real instruction that is not being replaced by a NOP.
    logic issue;
    assign issue = valid_in & ~bubble;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out               <= 1'b0;
            pc_out                  <= '0;
            val_rn_out              <= '0;
            val_rm_out              <= '0;
            dest_out                <= '0;
            src1_out                <= '0;
            src2_out                <= '0;
            shift_operand_out       <= '0;
            signed_imm_24_out       <= '0;
            status_out              <= '0;
            execute_command_out     <= '0;
            mem_read_out            <= 1'b0;
            mem_write_out           <= 1'b0;
            wb_enable_out           <= 1'b0;
            immediate_out           <= 1'b0;
            branch_taken_out        <= 1'b0;
            status_write_enable_out <= 1'b0;
            issued_count            <= '0;
        end else if (flush) begin
            // Flush beats freeze so a taken branch is never lost during a stall; count is kept.
            valid_out               <= 1'b0;
            pc_out                  <= '0;
            val_rn_out              <= '0;
            val_rm_out              <= '0;
            dest_out                <= '0;
            src1_out                <= '0;
            src2_out                <= '0;
            shift_operand_out       <= '0;
            signed_imm_24_out       <= '0;
            status_out              <= '0;
            execute_command_out     <= '0;
            mem_read_out            <= 1'b0;
            mem_write_out           <= 1'b0;
            wb_enable_out           <= 1'b0;
            immediate_out           <= 1'b0;
            branch_taken_out        <= 1'b0;
            status_write_enable_out <= 1'b0;
        end else if (!freeze) begin
            valid_out               <= issue;
            pc_out                  <= pc_in;
            val_rn_out              <= val_rn_in;
            val_rm_out              <= val_rm_in;
            dest_out                <= dest_in;
            src1_out                <= src1_in;
            src2_out                <= src2_in;
            shift_operand_out       <= shift_operand_in;
            signed_imm_24_out       <= signed_imm_24_in;
            status_out              <= status_in;
            immediate_out           <= immediate_in;
            execute_command_out     <= issue ? execute_command_in : 4'd0;
            mem_read_out            <= issue & mem_read_in;
            mem_write_out           <= issue & mem_write_in;
            wb_enable_out           <= issue & wb_enable_in;
            branch_taken_out        <= issue & branch_taken_in;
            status_write_enable_out <= issue & status_write_enable_in;
            if (issue) begin
                issued_count <= sat_inc(issued_count);
            end
        end
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the 5-stage ARM core; sits directly downstream of the decode-stage control unit and register file.
- Captures decoded control signals (execute_command, mem_read, mem_write, wb_enable, immediate, branch_taken, status_write_enable), operands and instruction fields each cycle, and presents them to the EX stage.
- Supports pipeline flush on a taken branch, freeze on a stall, and bubble insertion on a hazard.
- Keeps a saturating count of issued instructions for debug.

Parameters:
- DATA_W, 32, width of PC and register operands
- CNT_W, 16, width of issued-instruction counter

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  branch taken in EX; kill the instruction being captured
- freeze  in  1  hold all outputs (global stall)
- bubble  in  1  hazard detected; capture a NOP in place of the decoded instruction
- valid_in  in  1  decode stage holds a real instruction
- pc_in  in  DATA_W  PC+4 of the decoded instruction
- val_rn_in  in  DATA_W  Rn operand
- val_rm_in  in  DATA_W  Rm operand
- dest_in  in  4  destination register
- src1_in  in  4  Rn index, for forwarding
- src2_in  in  4  Rm/Rd index, for forwarding
- shift_operand_in  in  12  shifter operand field
- signed_imm_24_in  in  24  branch offset
- status_in  in  4  NZCV at decode
- execute_command_in  in  4  ALU command
- mem_read_in, mem_write_in, wb_enable_in, immediate_in, branch_taken_in, status_write_enable_in  in  1 each  control bits
- Outputs with the same names and _out suffix, same widths, plus valid_out  out  1
- issued_count  out  CNT_W  instructions issued to EX (saturating)

Behaviour:
- Reset (rst_n low, asynchronous): every output goes to 0 immediately, including issued_count; held while rst_n is low. First capture is on the first rising clk with rst_n high.
- Per rising edge, action priority: flush > freeze > bubble > load.
- Flush: all control outputs, valid_out, and all data/field outputs go to 0. Flush overrides freeze, so a branch is never lost during a stall.
- Freeze (no flush): every output holds its value, including issued_count.
- Bubble (no flush, no freeze):
  - Data/field outputs load from inputs.
  - execute_command_out, mem_read_out, mem_write_out, wb_enable_out, branch_taken_out, status_write_enable_out and valid_out go to 0.
  - immediate_out loads, so it is irrelevant to correctness.
- Load: all outputs take their inputs. valid_out = valid_in.
- The control-bit gate applies whenever valid_in = 0 on a load: the six side-effecting control outputs are forced to 0. A non-instruction can never write memory, registers or flags.
- Latency: exactly 1 cycle from inputs to outputs. No combinational path from any input to any output.
- issued_count increments by 1 on each load edge with valid_in = 1, and on no other edge (flush, freeze and bubble edges do not count). It saturates at 2^CNT_W − 1 and never wraps.
- Simultaneous flush + bubble + freeze: flush wins. Outputs are zero and the count is unchanged.
- Reset asserted mid-freeze or mid-stream: outputs clear immediately. The frozen instruction is discarded.

Test Plan:
- Reset then load: rst_n low 3 cycles → all outputs 0. Release, then apply valid_in=1, pc_in=0x0000_0010, execute_command_in=4'b0010, wb_enable_in=1, dest_in=4'd3 → next edge outputs equal the inputs, valid_out=1, issued_count=1.
- Freeze hold: loaded state as above; freeze=1 for 4 cycles while inputs change to pc_in=0x20 → outputs stay at pc 0x10, issued_count stays 1. Release → pc_out=0x20, issued_count=2.
- Flush priority: freeze=1, flush=1, bubble=1, valid_in=1, mem_write_in=1 → next edge all outputs 0 including mem_write_out and valid_out; issued_count unchanged.
- Bubble: bubble=1, valid_in=1, mem_write_in=1, status_write_enable_in=1, val_rn_in=0xDEAD_BEEF → mem_write_out=0, status_write_enable_out=0, valid_out=0, val_rn_out=0xDEAD_BEEF; count unchanged.
- Invalid gate: valid_in=0, wb_enable_in=1, branch_taken_in=1 → wb_enable_out=0, branch_taken_out=0, valid_out=0.
- Saturation and async reset: CNT_W=4; issue 20 valid loads → issued_count=15. Pull rst_n low between clock edges → all outputs 0 before the next clk edge.
